// File: rtl/writeback_if.sv
// Writeback bus bundle: ALU and load producers on one side, register-file
// write port plus scoreboard outputs on the other.
interface writeback_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          alu_valid;
   logic [5:0]    alu_rd;
   logic [31:0]   alu_data;
   logic          alu_ready;
   logic          mem_valid;
   logic [5:0]    mem_rd;
   logic [31:0]   mem_data;
   logic          mem_ready;
   logic          rd_req;
   logic          rf_write;
   logic [5:0]    rf_rd;
   logic [31:0]   rf_data;
   logic          read_stall;
   logic [63:0]   busy;
   logic [CW-1:0] count;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rd_req,
      input  alu_ready, mem_ready, rf_write, rf_rd, rf_data, read_stall, busy, count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rd_req,
      output alu_ready, mem_ready, rf_write, rf_rd, rf_data, read_stall, busy, count
   );
endinterface

// File: rtl/writeback_unit.sv
// Writeback queue: merges ALU and load results into an in-order FIFO and
// drains it into the single register-file port, yielding to decode reads
// unless the queue is full.
module writeback_unit #(
   parameter int DEPTH = 4
) (
   input logic        clk,
   input logic        rst_n,
   writeback_if.slave wb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [5:0]    rd_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          full;
   logic          empty;
   logic          enq;
   logic          pop;
   logic [5:0]    enq_rd;
   logic [31:0]   enq_data;
   logic          rf_write_q;
   logic [5:0]    rf_rd_q;
   logic [31:0]   rf_data_q;
   logic [63:0]   busy_c;

   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);

   // Readies look only at occupancy and mem_valid so producers never see rd_req.
   assign wb.mem_ready  = ~full;
   assign wb.alu_ready  = ~full & ~wb.mem_valid;
   assign wb.rf_write   = rf_write_q;
   assign wb.rf_rd      = rf_rd_q;
   assign wb.rf_data    = rf_data_q;
   assign wb.read_stall = rf_write_q;
   assign wb.count      = cnt;
   assign wb.busy       = busy_c;

   // Select the enqueue source (loads win) and decide whether to drain this cycle.
   always_comb begin
      enq      = (wb.mem_valid | wb.alu_valid) & ~full;
      enq_rd   = wb.mem_valid ? wb.mem_rd   : wb.alu_rd;
      enq_data = wb.mem_valid ? wb.mem_data : wb.alu_data;
      pop      = ~empty & (~wb.rd_req | full);
   end

   // Entry storage needs no reset; occupancy is tracked by cnt and the pointers.
   always_ff @(posedge clk) begin
      if (enq) begin
         rd_mem[wr_ptr]   <= enq_rd;
         data_mem[wr_ptr] <= enq_data;
      end
   end

   // Pointers, occupancy and the registered register-file write port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         rf_write_q <= 1'b0;
         rf_rd_q    <= '0;
         rf_data_q  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            rf_rd_q   <= rd_mem[rd_ptr];
            rf_data_q <= data_mem[rd_ptr];
         end
         cnt        <= cnt + CW'(enq) - CW'(pop);
         rf_write_q <= pop;
      end
   end

   // Pending-write scoreboard: every live slot plus the write in flight.
   always_comb begin
      logic [PW-1:0] off;
      busy_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_ptr;
         if ({1'b0, off} < cnt) begin
            busy_c[rd_mem[i]] = 1'b1;
         end
      end
      if (rf_write_q) begin
         busy_c[rf_rd_q] = 1'b1;
      end
   end
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue model.
module tb_writeback_unit;
   localparam int DEPTH = 4;

   typedef struct {
      logic [5:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   writeback_if #(.DEPTH(DEPTH)) bus ();

   writeback_unit #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus)
   );

   ent_t        mq[$];
   ent_t        dut_wr[$];
   ent_t        head;
   bit          m_full;
   logic        m_wr   = 1'b0;
   logic [5:0]  m_rd   = '0;
   logic [31:0] m_data = '0;
   int          total  = 0;
   int          bad    = 0;
   bit          check_en = 1'b0;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit av, input logic [5:0] ar, input logic [31:0] ad,
                                input bit mv, input logic [5:0] mr, input logic [31:0] md,
                                input bit rq);
      bus.alu_valid = av;
      bus.alu_rd    = ar;
      bus.alu_data  = ad;
      bus.mem_valid = mv;
      bus.mem_rd    = mr;
      bus.mem_data  = md;
      bus.rd_req    = rq;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model_busy();
      logic [63:0] b = '0;
      foreach (mq[i]) b[mq[i].rd] = 1'b1;
      if (m_wr) b[m_rd] = 1'b1;
      return b;
   endfunction

   // Reference model: a plain FIFO that drains when allowed and accepts loads first.
   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_wr   = 1'b0;
         m_rd   = '0;
         m_data = '0;
      end else begin
         m_full = (mq.size() == DEPTH);
         m_wr   = 1'b0;
         if (mq.size() > 0 && (!bus.rd_req || m_full)) begin
            head   = mq.pop_front();
            m_wr   = 1'b1;
            m_rd   = head.rd;
            m_data = head.data;
         end
         if (!m_full && bus.mem_valid)
            mq.push_back('{rd: bus.mem_rd, data: bus.mem_data});
         else if (!m_full && bus.alu_valid)
            mq.push_back('{rd: bus.alu_rd, data: bus.alu_data});
      end
   end

   // Compare every DUT output against the model mid-cycle and log actual writes.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("mem_ready",  64'(bus.mem_ready),  64'(mq.size() < DEPTH));
         checkOutput("alu_ready",  64'(bus.alu_ready),  64'(mq.size() < DEPTH && !bus.mem_valid));
         checkOutput("rf_write",   64'(bus.rf_write),   64'(m_wr));
         checkOutput("rf_rd",      64'(bus.rf_rd),      64'(m_rd));
         checkOutput("rf_data",    64'(bus.rf_data),    64'(m_data));
         checkOutput("read_stall", 64'(bus.read_stall), 64'(m_wr));
         checkOutput("busy",       bus.busy,            model_busy());
         checkOutput("count",      64'(bus.count),      64'(mq.size()));
         if (bus.rf_write === 1'b1)
            dut_wr.push_back('{rd: bus.rf_rd, data: bus.rf_data});
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      int nxt;
      bit acc;
      bit saw_block;
      bit av, mv, rq;

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      step();
      check_en = 1'b1;
      step();
      rst_n = 1'b1;
      checkOutput("reset count",     64'(bus.count), 64'd0);
      checkOutput("reset rf_write",  64'(bus.rf_write), 64'd0);
      checkOutput("reset rf_data",   64'(bus.rf_data), 64'd0);
      checkOutput("reset busy",      bus.busy, 64'd0);
      checkOutput("reset mem_ready", 64'(bus.mem_ready), 64'd1);
      checkOutput("reset alu_ready", 64'(bus.alu_ready), 64'd1);
      step();

      // Single ALU result: minimum latency and busy bit lifetime.
      applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("lat count k",    64'(bus.count), 64'd1);
      checkOutput("lat wr k",       64'(bus.rf_write), 64'd0);
      step();
      checkOutput("lat wr k+1",     64'(bus.rf_write), 64'd1);
      checkOutput("lat rd k+1",     64'(bus.rf_rd), 64'd5);
      checkOutput("lat data k+1",   64'(bus.rf_data), 64'h1234);
      checkOutput("lat busy5 k+1",  64'(bus.busy[5]), 64'd1);
      step();
      checkOutput("lat wr k+2",     64'(bus.rf_write), 64'd0);
      checkOutput("lat busy k+2",   bus.busy, 64'd0);

      // Load priority over ALU in the same cycle.
      applyStimulus(1, 3, 32'hA, 1, 4, 32'hB, 0);
      #1;
      checkOutput("prio alu_ready", 64'(bus.alu_ready), 64'd0);
      checkOutput("prio mem_ready", 64'(bus.mem_ready), 64'd1);
      step();
      applyStimulus(1, 3, 32'hA, 0, 0, 0, 0);
      #1;
      checkOutput("prio alu_ready2", 64'(bus.alu_ready), 64'd1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("prio first rd",   64'(bus.rf_rd), 64'd4);
      checkOutput("prio first data", 64'(bus.rf_data), 64'hB);
      step();
      checkOutput("prio second rd",   64'(bus.rf_rd), 64'd3);
      checkOutput("prio second data", 64'(bus.rf_data), 64'hA);
      step();

      // Continuous rd_req: no write until full, then a forced pop.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 6'(8 + i), 32'h20 + i, 0, 0, 0, 1);
         step();
         checkOutput("starve no write", 64'(bus.rf_write), 64'd0);
         checkOutput("starve count",    64'(bus.count), 64'(i + 1));
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      step();
      checkOutput("starve pop count", 64'(bus.count), 64'd3);
      checkOutput("starve pop wr",    64'(bus.rf_write), 64'd1);
      checkOutput("starve stall",     64'(bus.read_stall), 64'd1);
      checkOutput("starve pop rd",    64'(bus.rf_rd), 64'd8);
      step();
      checkOutput("starve hold wr",   64'(bus.rf_write), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (5) step();

      // Duplicate destination r7.
      applyStimulus(1, 7, 32'h1, 0, 0, 0, 0);
      step();
      applyStimulus(1, 7, 32'h2, 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("dup data1", 64'(bus.rf_data), 64'h1);
      checkOutput("dup busy7 a", 64'(bus.busy[7]), 64'd1);
      step();
      checkOutput("dup data2", 64'(bus.rf_data), 64'h2);
      checkOutput("dup busy7 b", 64'(bus.busy[7]), 64'd1);
      step();
      checkOutput("dup busy7 c", 64'(bus.busy[7]), 64'd0);
      checkOutput("dup hold data", 64'(bus.rf_data), 64'h2);

      // Full queue with mem_valid held: backpressure and wrap.
      dut_wr.delete();
      nxt = 0;
      saw_block = 1'b0;
      for (int it = 0; it < 60 && nxt < 6; it++) begin
         applyStimulus(0, 0, 0, 1, 6'(10 + nxt), 32'h100 + nxt, 1);
         #1;
         acc = bus.mem_ready;
         if (!acc) saw_block = 1'b1;
         step();
         if (acc) nxt++;
      end
      checkOutput("wrap accepted", 64'(nxt), 64'd6);
      checkOutput("wrap blocked",  64'(saw_block), 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (8) step();
      checkOutput("wrap writes", 64'(dut_wr.size()), 64'd6);
      for (int i = 0; i < 6 && i < dut_wr.size(); i++) begin
         checkOutput("wrap order rd",   64'(dut_wr[i].rd),   64'(10 + i));
         checkOutput("wrap order data", 64'(dut_wr[i].data), 64'(32'h100 + i));
      end

      // Reset with three entries queued.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 6'(20 + i), 32'h300 + i, 0, 0, 0, 1);
         step();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("mid count", 64'(bus.count), 64'd3);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checkOutput("mid rst count", 64'(bus.count), 64'd0);
      checkOutput("mid rst wr",    64'(bus.rf_write), 64'd0);
      checkOutput("mid rst busy",  bus.busy, 64'd0);
      dut_wr.delete();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (5) step();
      checkOutput("mid rst no writes", 64'(dut_wr.size()), 64'd0);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         av = 1'($urandom_range(0, 1));
         mv = ($urandom_range(0, 2) == 0);
         rq = ($urandom_range(0, 9) < 6);
         applyStimulus(av, 6'($urandom_range(0, 15)), $urandom,
                       mv, 6'($urandom_range(0, 15)), $urandom, rq);
         rst_n = ($urandom_range(0, 299) != 0);
         step();
      end
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (8) step();
      checkOutput("final drain count", 64'(bus.count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
